hazard_unit: RTL
================

# hazard_unit

Pipeline hazard detection and forwarding controller for the ARM pipeline. It sits in the decode stage, upstream of the control-unit NOP mux. It drives that mux's `select` to inject a bubble into ID/EX, gates the PC and IF/ID load enables, flushes IF/ID on taken branches, and produces operand-forwarding selects. A small FSM stretches load-use stalls over a configurable number of cycles, and a saturating counter tracks stall cycles.

## Interface
- `LOAD_STALL`, 1: stall cycles per load-use hazard. Legal range is 1..3.
- `CNT_W`, 16: width of the stall performance counter.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `rn_id`, `rm_id`, `rd_id` input 4 each: ID-stage source register numbers. `rd_id` is used as the store-data source.
- `use_rn`, `use_rm`, `use_rd` input 1 each: the corresponding ID source is actually read.
- `rd_ex`, `rd_mem`, `rd_wb` input 4 each: destination registers in EX, MEM and WB.
- `rf_ex`, `rf_mem`, `rf_wb` input 1 each: the stage writes the register file.
- `load_ex` input 1: the EX instruction is a load.
- `branch_taken` input 1: the ID-stage branch is resolved as taken.
- `fwd_a`, `fwd_b`, `fwd_c` output 2 each: operand source for Rn, Rm and Rd.
  - 00: register file
  - 01: EX
  - 10: MEM
  - 11: WB
- `nop_select` output 1: drives the CU mux `select`. 1 zeroes control into ID/EX.
- `pc_le` output 1: PC load enable.
- `ifid_le` output 1: IF/ID load enable.
- `ifid_clr` output 1: IF/ID synchronous clear (fetch flush).
- `stall_count` output `CNT_W`: total stall cycles since reset, saturating.

## Operation
- **Forwarding** (combinational, per source):
  - A source matches a stage when its `use_*` flag is 1, `stage_rf` is 1, `rd_stage` equals the source, and the source is not 15.
  - Priority is EX > MEM > WB. With no match the select is 00.
  - R15 is never forwarded.
- **Load-use hazard** (`luh`): `load_ex` & `rf_ex` & `rd_ex` != 15 & `rd_ex` matches any used ID source.
- **FSM states**: IDLE and STALL, with a 2-bit `remain` counter.
  - IDLE, `luh`=0: `nop_select`=0, `pc_le`=1, `ifid_le`=1.
  - IDLE, `luh`=1: `nop_select`=1, `pc_le`=0, `ifid_le`=0.
    - If `LOAD_STALL`>1, go to STALL with `remain`=`LOAD_STALL`-1.
    - Otherwise stay in IDLE.
  - STALL: `nop_select`=1, `pc_le`=0, `ifid_le`=0, and `remain` decrements each cycle.
    - When `remain`=1, return to IDLE at the next edge.
    - `luh` is ignored while in STALL.
- **Branch flush**: `ifid_clr` = `branch_taken` & stall inactive.
  - The stall condition is `luh`=1 in IDLE, or any cycle in STALL.
  - During a stall `branch_taken` is ignored. The ID instruction is held and re-evaluated after the stall.
  - `pc_le` stays 1 on a taken branch, so the PC loads the target.
- **Stall counter**: `stall_count` increments on every edge where `nop_select`=1 and `reset_n`=1. It saturates at all-ones.
- **Reset** (`reset_n`=0, effective immediately and at any time):
  - Sequential state: FSM=IDLE, `remain`=0, `stall_count`=0.
  - Outputs forced while reset is held: `nop_select`=1, `pc_le`=0, `ifid_le`=0, `ifid_clr`=0, `fwd_*`=00.
  - Reset in the middle of a stall aborts it. After release the block starts in IDLE.

## Timing
- Forwarding selects, `luh` and `ifid_clr` are combinational, with zero-cycle latency from inputs.
- A hazard detected in cycle N asserts `nop_select` in N. The stall is held through cycle N+`LOAD_STALL`-1. `pc_le`/`ifid_le` return to 1 in N+`LOAD_STALL`, unless a new hazard appears there.
- FSM state, `remain` and `stall_count` update on the rising edge of `clk`. `stall_count` reflects cycle N from N+1 onward.
- Back-to-back hazards in IDLE each produce a full `LOAD_STALL` window. There is no gap cycle required.

## Test plan
- **Forwarding priority**: `rn_id`=3, `use_rn`=1; `rd_ex`=`rd_mem`=`rd_wb`=3, all `rf`=1, `load_ex`=0 -> `fwd_a`=01. Drop `rf_ex` -> 10. Drop `rf_mem` -> 11. Set `rn_id`=15 -> 00.
- **Load-use, `LOAD_STALL`=1**: `load_ex`=1, `rf_ex`=1, `rd_ex`=5, `rm_id`=5, `use_rm`=1 for one cycle -> one cycle with `nop_select`=1 and `pc_le`=`ifid_le`=0; next cycle all clear; `stall_count`=1.
- **Load-use, `LOAD_STALL`=3**: same stimulus, inputs cleared after one cycle -> `nop_select`=1 for exactly 3 consecutive cycles; `stall_count`=3.
- **Simultaneous branch and hazard**: `branch_taken`=1 together with `luh` -> `ifid_clr`=0, stall taken. Next cycle, `branch_taken`=1 without hazard -> `ifid_clr`=1, `pc_le`=1.
- **Reset mid-stall** (`LOAD_STALL`=3): assert `reset_n`=0 in the 2nd stall cycle -> immediately `nop_select`=1, `pc_le`=0, `stall_count`=0. After release with no hazard -> `nop_select`=0 and `pc_le`=1 on the first cycle.
- **Counter saturation** (`CNT_W`=4): 20 stall cycles -> `stall_count` stops at 15.

Source files
------------

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : Decode-stage hazard detection and forwarding controller.
//               Produces per-operand forwarding selects, stretches load-use
//               stalls over LOAD_STALL cycles, flushes IF/ID on taken
//               branches and keeps a saturating count of stall cycles.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   LOAD_STALL  stall cycles per load-use hazard (legal range 1..3)
//   CNT_W       width of the stall performance counter
// Ports:
//   clk, reset_n                clock, asynchronous active-low reset
//   rn_id, rm_id, rd_id         ID-stage source registers (rd_id = store data)
//   use_rn, use_rm, use_rd      the corresponding source is actually read
//   rd_ex, rd_mem, rd_wb        destination registers in EX / MEM / WB
//   rf_ex, rf_mem, rf_wb        stage writes the register file
//   load_ex                     EX instruction is a load
//   branch_taken                ID-stage branch resolved taken
//   fwd_a, fwd_b, fwd_c         operand source for Rn / Rm / Rd
//                               (00 RF, 01 EX, 10 MEM, 11 WB)
//   nop_select                  1 injects a bubble into ID/EX
//   pc_le, ifid_le              PC / IF-ID load enables
//   ifid_clr                    IF/ID synchronous clear (fetch flush)
//   stall_count                 saturating stall cycle count since reset
// ============================================================================
module hazard_unit #(
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       rn_id,
  input  logic [3:0]       rm_id,
  input  logic [3:0]       rd_id,
  input  logic             use_rn,
  input  logic             use_rm,
  input  logic             use_rd,
  input  logic [3:0]       rd_ex,
  input  logic [3:0]       rd_mem,
  input  logic [3:0]       rd_wb,
  input  logic             rf_ex,
  input  logic             rf_mem,
  input  logic             rf_wb,
  input  logic             load_ex,
  input  logic             branch_taken,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       fwd_c,
  output logic             nop_select,
  output logic             pc_le,
  output logic             ifid_le,
  output logic             ifid_clr,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [3:0] PC_REG     = 4'd15;
  localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL - 1);
  localparam bit         MULTI      = (LOAD_STALL > 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_STALL = 1'b1
  } state_t;

  state_t     state;
  logic [1:0] remain;
  logic       luh;
  logic       stall_active;
  logic [1:0] sel_a, sel_b, sel_c;

  // EX > MEM > WB priority; R15 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [3:0] src, input logic used,
                                         input logic [3:0] dex, input logic wex,
                                         input logic [3:0] dmem, input logic wmem,
                                         input logic [3:0] dwb, input logic wwb);
    logic [1:0] sel;
    sel = 2'b00;
    if (used && src != PC_REG) begin
      if (wex && dex == src)        sel = 2'b01;
      else if (wmem && dmem == src) sel = 2'b10;
      else if (wwb && dwb == src)   sel = 2'b11;
    end
    return sel;
  endfunction

  always_comb begin
    sel_a = fwd_sel(rn_id, use_rn, rd_ex, rf_ex, rd_mem, rf_mem, rd_wb, rf_wb);
    sel_b = fwd_sel(rm_id, use_rm, rd_ex, rf_ex, rd_mem, rf_mem, rd_wb, rf_wb);
    sel_c = fwd_sel(rd_id, use_rd, rd_ex, rf_ex, rd_mem, rf_mem, rd_wb, rf_wb);
  end

  // Load result is not available until after MEM, so a dependent ID
  // instruction must wait rather than forward from EX.
  always_comb begin
    luh = load_ex && rf_ex && (rd_ex != PC_REG) &&
          ((use_rn && rn_id == rd_ex) ||
           (use_rm && rm_id == rd_ex) ||
           (use_rd && rd_id == rd_ex));
  end

  // A hazard stalls in the very cycle it is seen; STALL only covers the
  // remaining LOAD_STALL-1 cycles and ignores new hazards.
  always_comb begin
    stall_active = (state == S_STALL) || luh;
  end

  // Reset forces the pipeline into a safe bubble state immediately.
  always_comb begin
    fwd_a      = reset_n ? sel_a : 2'b00;
    fwd_b      = reset_n ? sel_b : 2'b00;
    fwd_c      = reset_n ? sel_c : 2'b00;
    nop_select = !reset_n || stall_active;
    pc_le      = reset_n && !stall_active;
    ifid_le    = reset_n && !stall_active;
    // A branch seen during a stall is re-evaluated once the ID instruction
    // is released, so it must not flush the held instruction now.
    ifid_clr   = reset_n && branch_taken && !stall_active;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      remain      <= 2'd0;
      stall_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (luh && MULTI) begin
            state  <= S_STALL;
            remain <= STALL_INIT;
          end
        end
        S_STALL: begin
          remain <= remain - 2'd1;
          if (remain == 2'd1) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state  <= S_IDLE;
          remain <= 2'd0;
        end
      endcase

      if (stall_active && stall_count != {CNT_W{1'b1}}) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
